// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the scanned seven-segment capture path.
// Segment codes are active low with bit7 as the decimal point.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [3:0] NIBBLE_ERR = 4'hF;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_B     = 8'h86;
  localparam logic [7:0] SEG_C     = 8'hAB;
  localparam logic [7:0] SEG_D     = 8'hA1;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Active-low segment pattern to display nibble; unknown patterns give
// NIBBLE_ERR with err set.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = NIBBLE_ERR;
    err    = 1'b0;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_BLANK: nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      default:   err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Rebuilds the 24-bit nibble frame from a scanned 6-digit display.
// Optional build macro SEG_DP_IGNORE_EN masks the decimal point before decode.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int STABLE_CYC   = 4,
  parameter int SCAN_TIMEOUT = 4000000
) (
  input  logic                  clkin,
  input  logic                  rst,
  input  logic [NUM_DIGITS-1:0] sel_n,
  input  logic [7:0]            seg_n,
  output logic [23:0]           data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  scan_lost,
  output scan_state_t           state_dbg
);

  localparam logic [7:0]  STABLE_MAX   = 8'(STABLE_CYC);
  localparam logic [7:0]  STABLE_LAST  = 8'(STABLE_CYC - 1);
  localparam logic [31:0] TIMEOUT_MAX  = 32'(SCAN_TIMEOUT);
  localparam logic [31:0] TIMEOUT_LAST = 32'(SCAN_TIMEOUT - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

  logic [NUM_DIGITS-1:0] sel_s1, sel_s2, sel_q, sel_act;
  logic [7:0]            seg_s1, seg_s2, seg_q, dec_in;
  logic [7:0]            stab_cnt;
  logic [31:0]           timer;
  logic [NUM_DIGITS-1:0] seen;
  logic [23:0]           shadow;
  logic                  err_flag;
  logic                  pair_same, one_hot, capture, publish, timeout_hit;
  logic [3:0]            dec_nib;
  logic                  dec_err;
  scan_state_t           state, state_nxt;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      sel_s1 <= '1;
      sel_s2 <= '1;
      sel_q  <= '1;
      seg_s1 <= '1;
      seg_s2 <= '1;
      seg_q  <= '1;
    end else begin
      sel_s1 <= sel_n;
      sel_s2 <= sel_s1;
      sel_q  <= sel_s2;
      seg_s1 <= seg_n;
      seg_s2 <= seg_s1;
      seg_q  <= seg_s2;
    end
  end

  assign sel_act   = ~sel_s2;
  assign pair_same = (sel_s2 == sel_q) && (seg_s2 == seg_q);
  assign one_hot   = (sel_act != '0) && ((sel_act & (sel_act - 1'b1)) == '0);
  // Saturating counter makes the capture a single event per stable pair.
  assign capture   = pair_same && (stab_cnt == STABLE_LAST) && one_hot;
  assign publish   = capture && (state == COLLECT) && sel_act[0] && (seen == ALL_SEEN);
  assign timeout_hit = !capture && (timer == TIMEOUT_LAST);

`ifdef SEG_DP_IGNORE_EN
  assign dec_in = seg_s2 | 8'h80;
`else
  assign dec_in = seg_s2;
`endif

  seg7_decode u_decode (
    .pattern (dec_in),
    .nibble  (dec_nib),
    .err     (dec_err)
  );

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      stab_cnt <= '0;
    end else if (!pair_same) begin
      stab_cnt <= '0;
    end else if (stab_cnt != STABLE_MAX) begin
      stab_cnt <= stab_cnt + 8'd1;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (capture) begin
      timer <= '0;
    end else if (timer != TIMEOUT_MAX) begin
      timer <= timer + 32'd1;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = COLLECT;
      COLLECT: if (timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign state_dbg = state;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      data        <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      scan_lost   <= 1'b0;
      seen        <= '0;
      shadow      <= '0;
      err_flag    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (capture) begin
        scan_lost <= 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel_act[i]) shadow[(NUM_DIGITS-1-i)*4 +: 4] <= dec_nib;
        end
        if (publish) begin
          data        <= shadow;
          frame_err   <= err_flag;
          frame_valid <= 1'b1;
          seen        <= sel_act;
          err_flag    <= dec_err;
        end else if (state == IDLE) begin
          seen     <= sel_act;
          err_flag <= dec_err;
        end else begin
          seen     <= seen | sel_act;
          err_flag <= err_flag | dec_err;
        end
      end else if (timeout_hit) begin
        scan_lost <= 1'b1;
        seen      <= '0;
        err_flag  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: expected frames are queued before the
// scan that triggers them and a monitor compares on every frame_valid pulse.
module tb_seg_scan_capture;
  import seg_scan_pkg::*;

  localparam int STABLE_CYC   = 4;
  localparam int SCAN_TIMEOUT = 300;
  localparam logic [47:0] PAT_123456 = {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
  localparam logic [47:0] PAT_AABCDA = {8'hFF, 8'hFF, 8'h86, 8'hAB, 8'hA1, 8'hFF};
  localparam logic [47:0] PAT_DP3    = {8'hF9, 8'hA4, 8'h7F, 8'h99, 8'h92, 8'h82};

  logic        clkin = 1'b0;
  logic        rst   = 1'b1;
  logic [5:0]  sel_n = '1;
  logic [7:0]  seg_n = '1;
  logic [23:0] data;
  logic        frame_valid, frame_err, scan_lost;
  scan_state_t state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [24:0] exp_q[$];
  logic [24:0] mon_e;

  // clock / reset
  always #5 clkin = ~clkin;

  seg_scan_capture #(
    .STABLE_CYC   (STABLE_CYC),
    .SCAN_TIMEOUT (SCAN_TIMEOUT)
  ) dut (
    .clkin       (clkin),
    .rst         (rst),
    .sel_n       (sel_n),
    .seg_n       (seg_n),
    .data        (data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .scan_lost   (scan_lost),
    .state_dbg   (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic show(input int idx, input logic [7:0] pat, input int n);
    sel_n = ~(6'd1 << idx);
    seg_n = pat;
    repeat (n) @(negedge clkin);
  endtask

  task automatic rot(input logic [47:0] pats);
    for (int i = 0; i < 6; i++) show(i, pats[47-8*i -: 8], 10);
  endtask

  // scoreboard monitor
  always @(negedge clkin) begin
    if (!rst && frame_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_publish actual data=%h expected no publish", data);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_data", {8'h0, data}, {8'h0, mon_e[23:0]});
        check("frame_err", {31'h0, frame_err}, {31'h0, mon_e[24]});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clkin);
    check("rst_data", {8'h0, data}, 32'h0);
    check("rst_valid", {31'h0, frame_valid}, 32'h0);
    check("rst_err", {31'h0, frame_err}, 32'h0);
    check("rst_lost", {31'h0, scan_lost}, 32'h0);
    check("rst_state", {31'h0, state_dbg}, {31'h0, IDLE});
    rst = 1'b0;

    // basic frame, then two rotations of a letters frame
    rot(PAT_123456);
    exp_q.push_back({1'b0, 24'h123456});
    rot(PAT_AABCDA);
    exp_q.push_back({1'b0, 24'hAABCDA});
    rot(PAT_AABCDA);
    exp_q.push_back({1'b0, 24'hAABCDA});

    // short-held pair and overlapping selects must not capture
    rot(PAT_123456);
    show(5, 8'hC0, 3);
    sel_n = 6'b111100;
    seg_n = 8'hC0;
    repeat (10) @(negedge clkin);
    exp_q.push_back({1'b0, 24'h123456});

    // lit decimal point on digit 3, then a clean frame
    rot(PAT_DP3);
`ifdef SEG_DP_IGNORE_EN
    exp_q.push_back({1'b0, 24'h12A456});
`else
    exp_q.push_back({1'b1, 24'h12F456});
`endif
    rot(PAT_123456);
    exp_q.push_back({1'b0, 24'h123456});
    show(0, 8'hF9, 10);
    repeat (4) @(negedge clkin);
    check("drain_1", exp_q.size(), 32'd0);

    // scan loss
    sel_n = 6'h3F;
    seg_n = 8'hFF;
    repeat (150) @(negedge clkin);
    check("lost_early", {31'h0, scan_lost}, 32'h0);
    check("state_collect", {31'h0, state_dbg}, {31'h0, COLLECT});
    repeat (200) @(negedge clkin);
    check("lost_set", {31'h0, scan_lost}, 32'h1);
    check("lost_data_held", {8'h0, data}, 32'h123456);
    check("lost_state", {31'h0, state_dbg}, {31'h0, IDLE});
    show(1, 8'hA4, 10);
    check("lost_clear", {31'h0, scan_lost}, 32'h0);
    rot(PAT_123456);
    exp_q.push_back({1'b0, 24'h123456});
    show(0, 8'hF9, 10);

    // reset mid-frame discards the partial frame
    show(1, 8'hA4, 10);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_data", {8'h0, data}, 32'h0);
    check("mid_rst_valid", {31'h0, frame_valid}, 32'h0);
    check("mid_rst_err", {31'h0, frame_err}, 32'h0);
    check("mid_rst_lost", {31'h0, scan_lost}, 32'h0);
    @(negedge clkin);
    rst = 1'b0;
    show(2, 8'hB0, 10);
    show(3, 8'h99, 10);
    show(4, 8'h92, 10);
    show(5, 8'h82, 10);
    show(0, 8'hC0, 10);
    show(1, 8'hA4, 10);
    exp_q.push_back({1'b0, 24'h023456});
    show(0, 8'hF9, 10);
    repeat (4) @(negedge clkin);
    check("drain_2", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive end of the multiplexed 6-digit seven-segment display interface: active-low digit selects plus active-low segment pattern.
- Filters and decodes the scanned display back into the 24-bit nibble frame the display driver was showing.
- Sits beside the countdown display logic for loopback self-check and for bench scoreboarding of displayed values.

Parameters:
- NUM_DIGITS, 6, digits per frame; fixed at 6 in this revision.
- STABLE_CYC, 4, clkin cycles a {sel_n, seg_n} pair must hold before capture; range 1..255.
- SCAN_TIMEOUT, 4000000, clkin cycles without an accepted capture before scan_lost asserts.

Ports:
- clkin  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sel_n  in  6  digit selects, active low; bit0 = sel1 = most-significant digit (data[23:20]), bit5 = sel6 = data[3:0]
- seg_n  in  8  segment pattern, active low, bit7 = decimal point
- data  out  24  last published frame, 6 nibbles
- frame_valid  out  1  one-cycle pulse when data updates
- frame_err  out  1  frame published with at least one undecodable digit; valid with frame_valid, held until next publish
- scan_lost  out  1  level; no accepted capture for SCAN_TIMEOUT cycles

Behaviour:
- Reset values: data = 0, frame_valid = 0, frame_err = 0, scan_lost = 0, FSM = IDLE, seen mask = 0, shadow = 0, timers = 0.
- Inputs pass a 2-flop synchronizer. All following latencies count from the synchronized value.
- Stability counter:
  - Clears when the synchronized {sel_n, seg_n} differs from its previous cycle value; otherwise increments, saturating at STABLE_CYC.
  - A capture fires once, on the cycle the count reaches STABLE_CYC, and only if exactly one sel_n bit is low.
  - Zero or multiple low selects means blanking or overlap: ignored, no capture.
- Decode:
  - C0→0, F9→1, A4→2, B0→3, 99→4, 92→5, 82→6, F8→7, 80→8, 90→9, FF→A (blank), 86→B, AB→C, A1→D.
  - Any other pattern → nibble F and sets the per-frame error flag.
- Capture action: write the nibble into the shadow slot for that digit; set its seen bit; clear the timeout counter. A repeated capture on the same digit overwrites the slot (latest wins); this absorbs the driver's one-tick segment/select skew.
- FSM:
  - IDLE → COLLECT on the first capture, which is stored.
  - COLLECT, capture of digit 0 while seen mask = all ones → publish, then start a new frame:
    - data <= shadow, frame_err <= error flag, frame_valid = 1 the next cycle.
    - Mask restarts with only bit0 set; error flag restarts from this capture's decode.
  - COLLECT, capture of digit 0 while the mask is incomplete → store the digit only, no publish.
- Timeout: counter runs in every state. At SCAN_TIMEOUT: scan_lost = 1, FSM → IDLE, mask and error flag clear, data held. scan_lost clears on the next capture.
- Simultaneous capture and timeout in the same cycle: capture wins; counter clears.
- Reset mid-frame: everything returns to reset values; the partial frame is discarded.

Optional Feature:
- SEG_DP_IGNORE_EN.
- Defined: seg_n[7] is forced to 1 before lookup, so a lit decimal point does not cause a decode error.
- Undefined: the full 8-bit pattern must match the table exactly; a lit DP decodes to F with error.

Decomposition:
- Package seg_scan_pkg holds:
  - the segment-code constants (SEG_0..SEG_9, SEG_BLANK, SEG_B, SEG_C, SEG_D);
  - NUM_DIGITS;
  - the FSM state typedef {IDLE, COLLECT};
  - NIBBLE_ERR = 4'hF.
- One combinational sub-module, seg7_decode (pattern in → nibble plus err out), shared with other display-side blocks.

Test Plan:
- Scan digits 1..6 with patterns F9,A4,B0,99,92,82, each held 10 cycles, then sel1 again → frame_valid pulse; data = 24'h123456; frame_err = 0.
- Scan showing AABCDA (FF,FF,86,AB,A1,FF), two full rotations → data = 24'hAABCDA on the second sel1 capture.
- Pair held 3 cycles (STABLE_CYC = 4) between valid digits → no capture from that pair; frame content unaffected.
- Digit 3 pattern 0x7F with a complete scan → data[15:12] = F, frame_err = 1; next clean frame → frame_err = 0.
- Scan stops with sel_n = 6'h3F for SCAN_TIMEOUT cycles → scan_lost = 1, data unchanged; a new valid capture → scan_lost = 0; the next complete frame publishes.
- Two sel_n bits low with a valid pattern → ignored. Assert rst mid-frame → all outputs return to 0 immediately.
